// File: rtl/mux_n_pipe.sv
// N-input, W-bit registered selector feeding a STAGES-deep valid-tagged pipeline.
// Optional macro MUX_N_PIPE_ZERO_SQUASH_EN turns captures of a zero destination into bubbles.
module mux_n_pipe #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned STAGES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    sel_err
);

  logic [WIDTH-1:0]             pick_c;
  logic                         sel_oor_c;
  logic                         cap_valid_c;
  logic [STAGES-1:0][WIDTH-1:0] data_q;
  logic [STAGES-1:0]            valid_q;

  // Input 0 is the fallback for any select that names no input.
  always_comb begin
    pick_c = in_bus[WIDTH-1:0];
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) pick_c = in_bus[i*WIDTH +: WIDTH];
    end
  end

  assign sel_oor_c = (32'(sel) >= NUM_IN);

`ifdef MUX_N_PIPE_ZERO_SQUASH_EN
  assign cap_valid_c = in_valid & (pick_c != '0);
`else
  assign cap_valid_c = in_valid;
`endif

  // Pipeline: flush beats stall beats advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= '0;
    end else if (flush) begin
      data_q  <= '0;
      valid_q <= '0;
    end else if (!stall) begin
      data_q[0]  <= pick_c;
      valid_q[0] <= cap_valid_c;
      for (int unsigned k = 1; k < STAGES; k++) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  // Sticky out-of-range flag, only on advancing edges with a valid request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (!flush && !stall && in_valid && sel_oor_c) begin
      sel_err <= 1'b1;
    end
  end

  assign out_data  = data_q[STAGES-1];
  assign out_valid = valid_q[STAGES-1];

endmodule

// File: tb/tb_mux_n_pipe.sv
// Randomised self-checking bench for mux_n_pipe: three configurations against a history-queue model.
module tb_mux_n_pipe;

`ifdef MUX_N_PIPE_ZERO_SQUASH_EN
  localparam bit SQUASH = 1'b1;
`else
  localparam bit SQUASH = 1'b0;
`endif

  localparam int S1 = 1, N1 = 3, W1 = 5;
  localparam int S3 = 3, N3 = 3, W3 = 5;
  localparam int S4 = 4, N4 = 4, W4 = 32;

  logic clk = 1'b0;
  logic reset, stall, flush, in_valid;
  logic [14:0]  bus1, bus3;
  logic [127:0] bus4;
  logic [1:0]   sel1, sel3, sel4;
  logic [4:0]   d1, d3;
  logic [31:0]  d4;
  logic         v1, v3, v4, e1, e3, e4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_bus(bus1), .sel(sel1), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(d1), .out_valid(v1), .sel_err(e1));

  mux_n_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .STAGES(3)) dut3 (
    .clk(clk), .reset(reset), .in_bus(bus3), .sel(sel3), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(d3), .out_valid(v3), .sel_err(e3));

  mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .STAGES(4)) dut4 (
    .clk(clk), .reset(reset), .in_bus(bus4), .sel(sel4), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(d4), .out_valid(v4), .sel_err(e4));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference entry {valid, data} for one capture, from the selection rules.
  function automatic logic [32:0] entry(input logic [127:0] bus, input int s, input int n,
                                        input int w, input logic v);
    logic [127:0] mask;
    logic [31:0]  pick;
    mask = (128'd1 << w) - 128'd1;
    pick = (s < n) ? 32'((bus >> (s * w)) & mask) : 32'(bus & mask);
    return {v && !(SQUASH && pick == 32'd0), pick};
  endfunction

  // Model: the last S advancing captures since reset/flush; output is the oldest once S exist.
  logic [32:0] h1[$], h3[$], h4[$];
  logic m_e1 = 1'b0, m_e3 = 1'b0, m_e4 = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      h1.delete(); h3.delete(); h4.delete();
      m_e1 = 1'b0; m_e3 = 1'b0; m_e4 = 1'b0;
    end else if (flush) begin
      h1.delete(); h3.delete(); h4.delete();
    end else if (!stall) begin
      h1.push_back(entry(128'(bus1), int'(sel1), N1, W1, in_valid));
      h3.push_back(entry(128'(bus3), int'(sel3), N3, W3, in_valid));
      h4.push_back(entry(bus4, int'(sel4), N4, W4, in_valid));
      if (h1.size() > S1) void'(h1.pop_front());
      if (h3.size() > S3) void'(h3.pop_front());
      if (h4.size() > S4) void'(h4.pop_front());
      if (in_valid && int'(sel1) >= N1) m_e1 = 1'b1;
      if (in_valid && int'(sel3) >= N3) m_e3 = 1'b1;
      if (in_valid && int'(sel4) >= N4) m_e4 = 1'b1;
    end
  end

  function automatic logic [32:0] model_out(input logic [32:0] oldest, input int sz, input int s);
    return (sz == s) ? oldest : 33'd0;
  endfunction

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    logic [32:0] x1, x3, x4;
    x1 = model_out((h1.size() > 0) ? h1[0] : 33'd0, h1.size(), S1);
    x3 = model_out((h3.size() > 0) ? h3[0] : 33'd0, h3.size(), S3);
    x4 = model_out((h4.size() > 0) ? h4[0] : 33'd0, h4.size(), S4);
    chk("m1_data",  64'(d1), 64'(x1[4:0]));
    chk("m1_valid", 64'(v1), 64'(x1[32]));
    chk("m1_err",   64'(e1), 64'(m_e1));
    chk("m3_data",  64'(d3), 64'(x3[4:0]));
    chk("m3_valid", 64'(v3), 64'(x3[32]));
    chk("m3_err",   64'(e3), 64'(m_e3));
    chk("m4_data",  64'(d4), 64'(x4[31:0]));
    chk("m4_valid", 64'(v4), 64'(x4[32]));
    chk("m4_err",   64'(e4), 64'(m_e4));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp4 [4];
    reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    bus1 = '0; bus3 = '0; bus4 = '0; sel1 = '0; sel3 = '0; sel4 = '0;
    repeat (2) tick();
    chk("rst_d1_data", 64'(d1), 64'd0);
    chk("rst_d1_valid", 64'(v1), 64'd0);
    chk("rst_d1_err", 64'(e1), 64'd0);
    chk("rst_d3_valid", 64'(v3), 64'd0);
    reset = 1'b0;

    // Basic path and out-of-range default on the default configuration.
    bus1 = {5'd31, 5'd8, 5'd3}; in_valid = 1'b1;
    sel1 = 2'd0; tick(); chk("basic_sel0", 64'(d1), 64'd3);  chk("basic_v0", 64'(v1), 64'd1);
    sel1 = 2'd1; tick(); chk("basic_sel1", 64'(d1), 64'd8);  chk("basic_v1", 64'(v1), 64'd1);
    sel1 = 2'd2; tick(); chk("basic_sel2", 64'(d1), 64'd31); chk("basic_err0", 64'(e1), 64'd0);
    sel1 = 2'd3; tick(); chk("oor_data", 64'(d1), 64'd3);    chk("oor_err", 64'(e1), 64'd1);

    reset = 1'b1; tick(); reset = 1'b0;
    sel1 = 2'd3; in_valid = 1'b0; tick();
    chk("oor_inv_err", 64'(e1), 64'd0);
    chk("oor_inv_valid", 64'(v1), 64'd0);
    chk("oor_inv_data", 64'(d1), 64'd3);

    // Stall holds the 3-stage pipe, then it drains in order.
    bus3 = {5'd31, 5'd8, 5'd3}; in_valid = 1'b1;
    sel3 = 2'd0; tick(); sel3 = 2'd1; tick(); sel3 = 2'd2; tick();
    chk("stall_pre", 64'(d3), 64'd3); chk("stall_pre_v", 64'(v3), 64'd1);
    stall = 1'b1; in_valid = 1'b0; sel3 = 2'd0;
    tick(); chk("stall_hold1", 64'(d3), 64'd3);
    tick(); chk("stall_hold2", 64'(d3), 64'd3); chk("stall_hold_v", 64'(v3), 64'd1);
    stall = 1'b0;
    tick(); chk("resume1", 64'(d3), 64'd8);  chk("resume1_v", 64'(v3), 64'd1);
    tick(); chk("resume2", 64'(d3), 64'd31); chk("resume2_v", 64'(v3), 64'd1);
    tick(); chk("resume3_v", 64'(v3), 64'd0);

    // Flush wins over stall.
    in_valid = 1'b1; sel3 = 2'd1; tick(); tick();
    flush = 1'b1; stall = 1'b1; tick();
    chk("flush_v3", 64'(v3), 64'd0); chk("flush_d3", 64'(d3), 64'd0); chk("flush_v1", 64'(v1), 64'd0);
    flush = 1'b0; stall = 1'b0;

    // Asynchronous reset clears loaded stages and the sticky flag mid-cycle.
    sel1 = 2'd3; tick(); sel1 = 2'd1; tick();
    chk("pre_arst_err", 64'(e1), 64'd1); chk("pre_arst_d1", 64'(d1), 64'd8);
    #2 reset = 1'b1;
    #1;
    chk("arst_d1", 64'(d1), 64'd0); chk("arst_v1", 64'(v1), 64'd0);
    chk("arst_err", 64'(e1), 64'd0); chk("arst_v3", 64'(v3), 64'd0);
    tick(); reset = 1'b0;

    // Wide 4-input, 4-stage configuration: every select returns its slice.
    bus4 = {32'd0, 32'd0, 32'd0, 32'd0, 32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF};
    exp4[0] = 32'hDEAD_BEEF; exp4[1] = 32'h1234_5678; exp4[2] = 32'h0BAD_BEEF; exp4[3] = 32'hCAFE_F00D;
    in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin sel4 = 2'(s); tick(); end
    sel4 = 2'd0;
    for (int s = 0; s < 4; s++) begin
      chk("sweep_data", 64'(d4), 64'(exp4[s]));
      chk("sweep_valid", 64'(v4), 64'd1);
      tick();
    end
    chk("sweep_err", 64'(e4), 64'd0);

    // Zero destination.
    bus1 = {5'd31, 5'd8, 5'd0}; sel1 = 2'd0; in_valid = 1'b1; tick();
    chk("zero_data", 64'(d1), 64'd0); chk("zero_valid", 64'(v1), SQUASH ? 64'd0 : 64'd1);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      bus1 = 15'($urandom); bus3 = 15'($urandom);
      bus4 = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) bus1[4:0] = 5'd0;
      sel1 = 2'($urandom); sel3 = 2'($urandom); sel4 = 2'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-input, W-bit registered selector with a pipeline stage chain; successor to the 3-way 5-bit destination-select mux.
- Used in the datapath for register-write destination selection (rt / rd / $31 / ...) carried with a valid bit through STAGES registers.
- Supports stall (hold), flush (bubble insert), out-of-range select detection and optional zero-destination squash.

Parameters:
- WIDTH, 5, data width of each input and of the output.
- NUM_IN, 3, number of selectable inputs (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- STAGES, 1, number of register stages between select and output (1..4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_bus  input  NUM_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SEL_W  selects input index.
- in_valid  input  1  qualifies sel/in_bus this cycle.
- stall  input  1  hold all stages.
- flush  input  1  clear all stages to bubble.
- out_data  output  WIDTH  selected data after STAGES cycles.
- out_valid  output  1  valid bit accompanying out_data.
- sel_err  output  1  sticky flag: a valid sel >= NUM_IN was captured.

Behaviour:
- Reset (async, active-high): every stage data = 0, every stage valid = 0, sel_err = 0; outputs read 0 immediately on reset assertion, with no clock required.
- Select:
  - Combinational pick = in_bus slice[sel] when sel < NUM_IN.
  - Otherwise pick = slice 0, i.e. the first input is the default.
- Per-edge priority (rising clk, reset low): flush > stall > advance.
  - flush=1: all stages data=0, valid=0; stall ignored; sel_err unaffected.
  - stall=1, flush=0: all stages hold; inputs ignored; sel_err not updated.
  - Advance: stage0 <= {in_valid, pick}; stage k <= stage k-1 for k=1..STAGES-1.
- Outputs: out_data/out_valid = last stage. Latency STAGES cycles of non-stalled clocks.
- sel_err:
  - Set on an advancing edge where in_valid=1 and sel >= NUM_IN.
  - Once set, holds until reset.
  - Invalid selects with in_valid=0 do not set it.
- in_valid=0: the data is still captured; out_valid=0 marks it a bubble.
- Simultaneous flush and stall: flush wins, result is a bubble in every stage.
- Reset asserted mid-stream: all in-flight entries are lost; out_valid=0 and out_data=0 the same instant.
- NUM_IN == 2**SEL_W: no out-of-range value exists; sel_err stays 0.

Optional Feature:
- Macro: MUX_N_PIPE_ZERO_SQUASH_EN
- Defined:
  - At stage0 capture, valid <= in_valid & (pick != 0). Writes to destination 0 ($0) become bubbles.
  - Data is still captured as 0.
  - sel_err behaviour is unchanged.
- Undefined: valid <= in_valid regardless of the data value.

Test Plan:
- Reset: assert reset mid-cycle with stages loaded -> out_data=0, out_valid=0, sel_err=0 asynchronously, before the next clk edge.
- Basic path (defaults):
  - Stimulus: in_bus={5'd31,5'd8,5'd3}, in_valid=1; sel=0,1,2 on successive cycles.
  - Response: out_data=3,8,31 with out_valid=1, each 1 cycle later.
- Out-of-range: sel=3, in_valid=1 -> out_data=3 (input 0) next cycle, sel_err=1; sel=3 with in_valid=0 on a fresh reset -> sel_err stays 0.
- Stall/flush (STAGES=3):
  - Stall: push 3 valid items, stall 2 cycles -> outputs frozen, then resume with the correct order and 3-cycle latency.
  - Flush with stall=1 -> all stages bubbles, out_valid=0 next edge.
- Parameter sweep: NUM_IN=4, SEL_W=2, WIDTH=32, STAGES=4 -> each sel 0..3 returns its slice after 4 edges; sel_err never set.
- Zero squash:
  - With MUX_N_PIPE_ZERO_SQUASH_EN: select input holding 0 with in_valid=1 -> out_valid=0, out_data=0.
  - Without the macro: out_valid=1, out_data=0.
